key_repeat_ctrl: RTL

- Input conditioner between the four raw push-buttons and the grid/game controller.
- Per key: synchronises, debounces, detects the press edge and generates auto-repeat events while the key is held.
- Events are latched and released as 1-cycle op_keys pulses, aligned to the frame boundary (rising edge of draw_finish), so the game logic sees at most one event per key per frame.

---
 rtl/key_repeat_ctrl_if.sv | 31 +++
 rtl/key_repeat_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/key_repeat_ctrl_if.sv
// Signal bundle between the push-button conditioner and its surroundings.
// Handshake semantics: there is no valid/ready pair. key_raw and draw_finish
// are free-running levels sampled every vga_clk. op_keys is a pure 1-cycle
// pulse per key: the consumer must act on every cycle it is high and cannot
// stall it. key_held is a level. fsm_state carries the per-key repeat FSM
// state (2 bits per key, key i in [2*i+1:2*i]) for observation.
interface key_repeat_ctrl_if;
  logic [3:0] key_raw;
  logic       draw_finish;
  logic [3:0] op_keys;
  logic [3:0] key_held;
  logic [7:0] fsm_state;

  // Environment side: drives buttons and frame strobe, observes events.
  modport master (
    output key_raw,
    output draw_finish,
    input  op_keys,
    input  key_held,
    input  fsm_state
  );

  // Conditioner side.
  modport slave (
    input  key_raw,
    input  draw_finish,
    output op_keys,
    output key_held,
    output fsm_state
  );
endinterface

// File: rtl/key_repeat_ctrl.sv
// Push-button conditioner: per key a 2-flop synchroniser, a debouncer and a
// press/auto-repeat FSM. Events are latched and released as 1-cycle op_keys
// pulses on the rising edge of draw_finish, so the game logic sees at most
// one event per key per frame.
module key_repeat_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         REPEAT_DELAY    = 6250000,
  parameter int         REPEAT_RATE     = 2500000,
  parameter logic [3:0] REPEAT_MASK     = 4'b1110
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  key_repeat_ctrl_if.slave  bus
);

  // One counter width serves both debounce and repeat timers; sized from the
  // largest period so no counter can overflow before its terminal compare.
  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int CW     = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    held;
  logic [CW-1:0] deb_cnt   [4];
  state_t        state     [4];
  state_t        state_nxt [4];
  logic [CW-1:0] tmr       [4];
  logic [CW-1:0] tmr_nxt   [4];
  logic [3:0]    ev;
  logic [3:0]    pending;
  logic [3:0]    op_q;
  logic          df_d;
  logic          fe;

  // Two-stage synchroniser for the asynchronous buttons.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.key_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after it has differed from the held
  // level for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= '0;
      for (int i = 0; i < 4; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == held[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          held[i]    <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Repeat FSM state and timer registers.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        tmr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
        tmr[i]   <= tmr_nxt[i];
      end
    end
  end

  // Repeat FSM next-state and event generation. A released key always
  // returns to IDLE, and that wins over any event due in the same cycle.
  // Keys without repeat park in REPEAT with the timer frozen until release.
  always_comb begin
    ev = '0;
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      tmr_nxt[i]   = tmr[i];
      if (!held[i]) begin
        state_nxt[i] = IDLE;
        tmr_nxt[i]   = '0;
      end else begin
        case (state[i])
          IDLE: begin
            ev[i]        = 1'b1;
            tmr_nxt[i]   = '0;
            state_nxt[i] = REPEAT_MASK[i] ? DELAY : REPEAT;
          end
          DELAY: begin
            if (tmr[i] == DLY_LAST) begin
              ev[i]        = 1'b1;
              tmr_nxt[i]   = '0;
              state_nxt[i] = REPEAT;
            end else begin
              tmr_nxt[i] = tmr[i] + 1'b1;
            end
          end
          REPEAT: begin
            if (REPEAT_MASK[i]) begin
              if (tmr[i] == RATE_LAST) begin
                ev[i]      = 1'b1;
                tmr_nxt[i] = '0;
              end else begin
                tmr_nxt[i] = tmr[i] + 1'b1;
              end
            end
          end
          default: begin
            state_nxt[i] = IDLE;
            tmr_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  // Frame strobe: a single cycle per low-to-high transition of draw_finish.
  assign fe = bus.draw_finish & ~df_d;

  // Event latch and frame-aligned release. An event raised in the strobe
  // cycle goes straight into this release instead of the cleared latch.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      df_d    <= 1'b0;
      pending <= '0;
      op_q    <= '0;
    end else begin
      df_d <= bus.draw_finish;
      if (fe) begin
        op_q    <= pending | ev;
        pending <= '0;
      end else begin
        op_q    <= '0;
        pending <= pending | ev;
      end
    end
  end

  // Pack the FSM states for observation.
  always_comb begin
    bus.fsm_state = '0;
    for (int i = 0; i < 4; i++) begin
      bus.fsm_state[2*i +: 2] = state[i];
    end
  end

  assign bus.op_keys  = op_q;
  assign bus.key_held = held;

endmodule
